// File: rtl/clkmeas_pkg.sv
// Shared constants for the clock-measurement block: FSM state encodings.
package clkmeas_pkg;

    localparam int unsigned ST_W = 2;

    localparam logic [ST_W-1:0] ST_IDLE    = 2'd0;
    localparam logic [ST_W-1:0] ST_MEASURE = 2'd1;
    localparam logic [ST_W-1:0] ST_TIMEOUT = 2'd2;

endpackage

// File: rtl/sig_sync.sv
// Two-flop synchroniser bringing an asynchronous level into the clk_i domain.
module sig_sync (
    input  logic clk_i,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic s1;

    always_ff @(posedge clk_i) begin
        if (reset) begin
            s1 <= 1'b0;
            q  <= 1'b0;
        end else begin
            s1 <= d;
            q  <= s1;
        end
    end

endmodule

// File: rtl/clkmeas.sv
// Measures the half-period of sig_i in clk_i cycles, reporting it as a clkgen maxval,
// with lock detection between consecutive measurements and a no-edge timeout.
module clkmeas
    import clkmeas_pkg::*;
#(
    parameter int unsigned N   = 8,
    parameter int unsigned TOL = 0
) (
    input  logic         clk_i,
    input  logic         reset,
    input  logic         sig_i,
    output logic [N-1:0] period_o,
    output logic         valid_o,
    output logic         locked_o,
    output logic         timeout_o
);

    localparam int unsigned    CW       = N + 1;
    localparam logic [CW-1:0]  CNT_SAT  = {1'b1, {N{1'b0}}};
    localparam logic [CW-1:0]  CNT_LAST = {1'b0, {N{1'b1}}};
    localparam logic [CW-1:0]  TOL_W    = CW'(TOL);

    logic            s2;
    logic            s3;
    logic            sig_edge;
    logic [ST_W-1:0] state;
    logic [ST_W-1:0] state_nxt;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   cnt_nxt;
    logic [N-1:0]    period_nxt;
    logic            valid_nxt;
    logic            locked_nxt;
    logic            timeout_nxt;
    logic            prev_valid;
    logic            prev_valid_nxt;
    logic [CW-1:0]   meas_w;
    logic [CW-1:0]   prev_w;
    logic [CW-1:0]   diff;

    sig_sync u_sync (
        .clk_i (clk_i),
        .reset (reset),
        .d     (sig_i),
        .q     (s2)
    );

    assign sig_edge = s2 ^ s3;

    // Widened compare so the absolute difference never wraps.
    assign meas_w = {1'b0, cnt[N-1:0]};
    assign prev_w = {1'b0, period_o};
    assign diff   = (meas_w >= prev_w) ? (meas_w - prev_w) : (prev_w - meas_w);

    always_ff @(posedge clk_i) begin
        if (reset) begin
            state      <= ST_IDLE;
            s3         <= 1'b0;
            cnt        <= '0;
            period_o   <= '0;
            valid_o    <= 1'b0;
            locked_o   <= 1'b0;
            timeout_o  <= 1'b0;
            prev_valid <= 1'b0;
        end else begin
            state      <= state_nxt;
            s3         <= s2;
            cnt        <= cnt_nxt;
            period_o   <= period_nxt;
            valid_o    <= valid_nxt;
            locked_o   <= locked_nxt;
            timeout_o  <= timeout_nxt;
            prev_valid <= prev_valid_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        period_nxt     = period_o;
        valid_nxt      = 1'b0;
        locked_nxt     = locked_o;
        timeout_nxt    = timeout_o;
        prev_valid_nxt = prev_valid;

        if (sig_edge) begin
            cnt_nxt = '0;
        end else if (cnt != CNT_SAT) begin
            cnt_nxt = cnt + CW'(1);
        end else begin
            cnt_nxt = cnt;
        end

        case (state)
            ST_IDLE: begin
                if (sig_edge) begin
                    state_nxt      = ST_MEASURE;
                    prev_valid_nxt = 1'b0;
                end
            end
            // An edge on the saturating cycle wins over the timeout.
            ST_MEASURE: begin
                if (sig_edge) begin
                    period_nxt     = cnt[N-1:0];
                    valid_nxt      = 1'b1;
                    locked_nxt     = prev_valid && (diff <= TOL_W);
                    prev_valid_nxt = 1'b1;
                end else if (cnt == CNT_LAST) begin
                    state_nxt      = ST_TIMEOUT;
                    timeout_nxt    = 1'b1;
                    locked_nxt     = 1'b0;
                    prev_valid_nxt = 1'b0;
                end
            end
            ST_TIMEOUT: begin
                if (sig_edge) begin
                    state_nxt   = ST_MEASURE;
                    timeout_nxt = 1'b0;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule
